// File: rtl/bcd_counter_n.sv
// rtl/bcd_counter_n.sv - parametrised multi-digit BCD up/down counter with load, terminal count and sticky wrap
module bcd_counter_n #(
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   CNT10,
  output logic                  tc,
  output logic                  wrap
);

  logic [4*DIGITS-1:0] r_cnt;
  logic                r_wrap;

  logic [4*DIGITS-1:0] w_next;
  logic [4*DIGITS-1:0] w_load;
  logic [DIGITS:0]     w_lo9;
  logic [DIGITS:0]     w_lo0;
  logic [3:0]          w_dig;
  logic [3:0]          w_ld_dig;
  logic                w_edge_wrap;

  // Digits are clamped to 9 before stepping so a corrupted field still lands in 0..9.
  always_comb begin
    w_next   = '0;
    w_load   = '0;
    w_lo9    = '0;
    w_lo0    = '0;
    w_dig    = '0;
    w_ld_dig = '0;
    w_lo9[0] = 1'b1;
    w_lo0[0] = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      w_dig    = (r_cnt[4*i +: 4] > 4'd9) ? 4'd9 : r_cnt[4*i +: 4];
      w_ld_dig = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
      w_load[4*i +: 4] = w_ld_dig;
      if (up_dn) begin
        if (!w_lo9[i])
          w_next[4*i +: 4] = w_dig;
        else
          w_next[4*i +: 4] = (w_dig == 4'd9) ? 4'd0 : w_dig + 4'd1;
      end else begin
        if (!w_lo0[i])
          w_next[4*i +: 4] = w_dig;
        else
          w_next[4*i +: 4] = (w_dig == 4'd0) ? 4'd9 : w_dig - 4'd1;
      end
      w_lo9[i+1] = w_lo9[i] & (w_dig == 4'd9);
      w_lo0[i+1] = w_lo0[i] & (w_dig == 4'd0);
    end
  end

  assign w_edge_wrap = up_dn ? w_lo9[DIGITS] : w_lo0[DIGITS];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_wrap <= 1'b0;
    end else if (load) begin
      r_cnt  <= w_load;
      r_wrap <= 1'b0;
    end else if (en) begin
      r_cnt <= w_next;
      if (w_edge_wrap)
        r_wrap <= 1'b1;
    end
  end

  assign CNT10 = r_cnt;
  assign wrap  = r_wrap;
  assign tc    = en & ~load & ~rst & w_edge_wrap;

endmodule

// File: tb/tb_bcd_counter_n.sv
// tb/tb_bcd_counter_n.sv - scoreboard bench driving 2-, 3- and 4-digit counters with shared stimulus
module tb_bcd_counter_n;

  logic        clk;
  logic        rst;
  logic        en;
  logic        up_dn;
  logic        load;
  logic [15:0] load_val;

  logic [7:0]  cnt2;
  logic [11:0] cnt3;
  logic [15:0] cnt4;
  logic        tc2, tc3, tc4;
  logic        wrap2, wrap3, wrap4;

  int total = 0;
  int bad   = 0;

  logic [16:0]       m_st [3];
  logic [2:0][16:0]  sb_q [$];

  bcd_counter_n #(.DIGITS(2)) u_d2 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val[7:0]), .CNT10(cnt2), .tc(tc2), .wrap(wrap2)
  );

  bcd_counter_n #(.DIGITS(3)) u_d3 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val[11:0]), .CNT10(cnt3), .tc(tc3), .wrap(wrap3)
  );

  bcd_counter_n #(.DIGITS(4)) u_d4 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val[15:0]), .CNT10(cnt4), .tc(tc4), .wrap(wrap4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int pow10(input int d);
    int m = 1;
    for (int i = 0; i < d; i++) m = m * 10;
    return m;
  endfunction

  function automatic int bcd2int(input logic [15:0] c, input int d);
    int v = 0;
    for (int i = d - 1; i >= 0; i--) v = v * 10 + int'(c[4*i +: 4]);
    return v;
  endfunction

  function automatic logic [15:0] int2bcd(input int v, input int d);
    logic [15:0] c = '0;
    int t = v;
    for (int i = 0; i < d; i++) begin
      c[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return c;
  endfunction

  function automatic logic [16:0] mdl_next(input int d, input logic [16:0] st,
                                           input logic r, input logic l,
                                           input logic [15:0] lv, input logic e,
                                           input logic u);
    logic [15:0] c = '0;
    int v;
    int m;
    if (r) return '0;
    if (l) begin
      for (int i = 0; i < d; i++)
        c[4*i +: 4] = (lv[4*i +: 4] > 4'd9) ? 4'd9 : lv[4*i +: 4];
      return {1'b0, c};
    end
    if (!e) return st;
    m = pow10(d);
    v = bcd2int(st[15:0], d);
    if (u) begin
      if (v == m - 1) return {1'b1, 16'h0};
      return {st[16], int2bcd(v + 1, d)};
    end
    if (v == 0) return {1'b1, int2bcd(m - 1, d)};
    return {st[16], int2bcd(v - 1, d)};
  endfunction

  function automatic logic mdl_tc(input int d, input logic [16:0] st, input logic r,
                                  input logic l, input logic e, input logic u);
    int v = bcd2int(st[15:0], d);
    return e & ~l & ~r & (u ? (v == pow10(d) - 1) : (v == 0));
  endfunction

  function automatic logic [16:0] obs(input int k);
    case (k)
      0:       return {wrap2, 8'h0, cnt2};
      1:       return {wrap3, 4'h0, cnt3};
      default: return {wrap4, cnt4};
    endcase
  endfunction

  function automatic logic obs_tc(input int k);
    case (k)
      0:       return tc2;
      1:       return tc3;
      default: return tc4;
    endcase
  endfunction

  task automatic cycle(input logic r, input logic l, input logic [15:0] lv,
                       input logic e, input logic u);
    logic [2:0][16:0] ex;
    logic [2:0][16:0] got_exp;
    logic [16:0] o;
    @(negedge clk);
    rst = r; load = l; load_val = lv; en = e; up_dn = u;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("tc_d%0d", k + 2), 32'(obs_tc(k)), 32'(mdl_tc(k + 2, m_st[k], r, l, e, u)));
      ex[k]   = mdl_next(k + 2, m_st[k], r, l, lv, e, u);
      m_st[k] = ex[k];
    end
    sb_q.push_back(ex);
    @(posedge clk);
    #1;
    got_exp = sb_q.pop_front();
    for (int k = 0; k < 3; k++) begin
      o = obs(k);
      chk($sformatf("cnt_d%0d", k + 2), 32'(o[15:0]), 32'(got_exp[k][15:0]));
      chk($sformatf("wrap_d%0d", k + 2), 32'(o[16]), 32'(got_exp[k][16]));
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; load_val = '0; en = 1'b0; up_dn = 1'b1;
    for (int k = 0; k < 3; k++) m_st[k] = '0;

    cycle(1, 0, 16'h0, 0, 1);
    for (int n = 0; n < 100; n++) cycle(0, 0, 16'h0, 1, 1);
    cycle(0, 0, 16'h0, 0, 1);

    cycle(0, 1, 16'h0005, 0, 1);
    for (int n = 0; n < 7; n++) cycle(0, 0, 16'h0, 1, 0);

    cycle(0, 1, 16'h00A7, 1, 1);
    cycle(0, 0, 16'h0, 0, 1);

    cycle(0, 1, 16'h0015, 0, 1);
    for (int n = 0; n < 4; n++) cycle(0, 0, 16'h0, 1, 1);
    for (int n = 0; n < 3; n++) cycle(0, 0, 16'h0, 0, 1);
    cycle(0, 0, 16'h0, 1, 1);

    cycle(0, 1, 16'h0999, 0, 1);
    cycle(0, 0, 16'h0, 1, 1);
    cycle(0, 0, 16'h0, 1, 0);

    cycle(0, 1, 16'h0999, 0, 1);
    cycle(1, 1, 16'h0999, 1, 1);

    cycle(0, 1, 16'hFFFF, 0, 1);
    cycle(0, 0, 16'h0, 1, 1);
    cycle(0, 0, 16'h0, 1, 1);

    for (int n = 0; n < 300; n++)
      cycle(($urandom_range(0, 29) == 0), ($urandom_range(0, 9) == 0), 16'($urandom),
            ($urandom_range(0, 3) != 0), 1'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_counter_n.md
Name: bcd_counter_n

Overview:
- Parametrised multi-digit decimal (BCD) counter. It is the successor to the single-digit 0-9 counter.
- Each digit is a 4-bit BCD field counting 0-9; digits cascade decade-style.
- Adds up/down counting, count enable, synchronous parallel load, terminal-count output and a sticky wrap flag.
- Used as the event/time counter feeding the 7-segment display path in lab designs.

Parameters:
- DIGITS, 2, number of BCD digits (1..8); count range 0 .. 10^DIGITS-1

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- en  input  1  count enable; one step per clk edge while high
- up_dn  input  1  1 = count up, 0 = count down; sampled with en
- load  input  1  synchronous parallel load
- load_val  input  4*DIGITS  BCD load value; digit i at bits [4i+3:4i]
- CNT10  output  4*DIGITS  registered BCD count; digit 0 = least significant
- tc  output  1  combinational terminal count: high when the next enabled edge wraps
- wrap  output  1  registered sticky flag: at least one wrap since the last rst/load

Behaviour:
- All state updates occur on the rising clk edge. Priority is rst > load > en.
- rst=1: CNT10 <= 0, wrap <= 0. Both outputs read 0 in the cycle after the reset edge. Reset mid-count discards the count and any pending load.
- load=1 (rst=0): each digit i <= load_val digit i, with any digit value >9 replaced by 9 (saturate). wrap <= 0. en is ignored that cycle.
- en=0, load=0: CNT10 and wrap hold.
- en=1, up_dn=1 (count up):
  - digit 0 increments; 9 -> 0.
  - digit i (i>0) steps only when digits 0..i-1 are all 9.
  - All-9s -> all-0s; wrap <= 1 on that edge.
- en=1, up_dn=0 (count down):
  - digit 0 decrements; 0 -> 9.
  - digit i steps only when digits 0..i-1 are all 0.
  - All-0s -> all-9s; wrap <= 1 on that edge.
- Each digit remains in 0..9 at all times; no binary carry between digit fields. The next value is a pure function of the current CNT10, en and up_dn.
- tc = en & ~load & ~rst & (up_dn ? all digits == 9 : all digits == 0). It is combinational and has zero latency.
- wrap stays set until rst or load. A wrap on the same edge as a held wrap keeps it at 1.
- up_dn may change on any cycle; direction takes effect on the same edge it is sampled with en.
- Latency: the count changes one clk edge after en is sampled. There is no pipeline.
- DIGITS=1 degenerates to a single 0-9 up/down decade counter with load.
- If a digit is held illegal (>9), that can only come from a defect. The next count step must still yield a legal digit: treat >9 as 9 for up/down stepping.

Test Plan:
- DIGITS=2. Assert rst for 1 cycle, then en=1, up_dn=1 for 100 cycles -> CNT10 steps 0x00, 0x01 .. 0x09, 0x10 .. 0x99, 0x00. tc=1 only while CNT10=0x99. wrap=1 after the 100th edge.
- DIGITS=2. Load 0x05, then en=1, up_dn=0 for 7 cycles -> 0x04, 0x03, 0x02, 0x01, 0x00, 0x99, 0x98. tc high only at 0x00. wrap rises on the 0x00 -> 0x99 edge.
- DIGITS=2. load=1 with load_val=0xA7 and en=1 in the same cycle -> CNT10=0x97 next cycle with no count step; wrap cleared.
- DIGITS=2. Count up to 0x19, drop en for 3 cycles, then en=1 for 1 cycle -> CNT10 holds 0x19, then becomes 0x20.
- DIGITS=3. At 0x999 assert rst and load together with en=1 -> CNT10=0x000 and wrap=0; the rst priority beats load and the wrap.
- DIGITS=4. Load 0x0999 and count up 1 -> 0x1000. Then switch to up_dn=0 for 1 cycle -> 0x0999 (multi-digit borrow ripple).
